ber_sync_ctrl: RTL and testbench

- Receiver synchronisation controller for the PRBS9/BPSK/RC/BER link.
- Sweeps every RX sampling phase (0..OS-1) and every reference-PRBS alignment delay (0..NLAT-1). For each candidate it clears the BER checker and counts bit errors over a fixed symbol window.
- It then applies the candidate with the fewest errors, asserts lock, and keeps monitoring the error rate.
- It sits between the BER checker (error strobes in) and the RX sampler/reference-PRBS delay (phase/delay selects out), replacing the manual offset switches.

---
 rtl/ber_sync_ctrl_pkg.sv | 19 +
 rtl/ber_sync_ctrl_window_cnt.sv | 52 +++++
 rtl/ber_sync_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ber_sync_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_sync_ctrl_pkg.sv
// Shared definitions for the receiver synchronisation controller:
// controller state encoding and default link parameters.
package ber_sync_ctrl_pkg;

    localparam int unsigned DEF_OS       = 4;
    localparam int unsigned DEF_NLAT     = 511;
    localparam int unsigned DEF_WINDOW   = 64;
    localparam int unsigned DEF_SETTLE   = 8;
    localparam int unsigned DEF_LOCK_THR = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_APPLY   = 3'd3,
        ST_LOCKED  = 3'd4
    } sync_state_e;

endpackage

// File: rtl/ber_sync_ctrl_window_cnt.sv
// ber_window_cnt: symbol/error counter pair over a WINDOW-symbol window.
// done_c_o flags the closing tick; err_sum_c_o is the error total
// including the current tick, so the closing count is usable at once.
module ber_window_cnt
    import ber_sync_ctrl_pkg::*;
#(
    parameter int unsigned WINDOW = DEF_WINDOW
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           en_i,
    input  logic                           tick_i,
    input  logic                           err_i,
    output logic                           done_c_o,
    output logic [$clog2(WINDOW+1)-1:0]    err_sum_c_o
);
    localparam int unsigned CW = $clog2(WINDOW + 1);

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          cnt_tick;

    assign cnt_tick    = en_i && tick_i;
    assign done_c_o    = cnt_tick && (tick_cnt_q == CW'(WINDOW - 1));
    assign err_sum_c_o = err_cnt_q + CW'(cnt_tick && err_i);

    // Next counter values: clear, restart at window end, or accumulate.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (clear_i || done_c_o) begin
            tick_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (cnt_tick) begin
            tick_cnt_d = tick_cnt_q + CW'(1);
            err_cnt_d  = err_sum_c_o;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: rtl/ber_sync_ctrl.sv
// ber_sync_ctrl: sweeps all (phase, delay) candidates, applies the one with
// the fewest bit errors, then monitors the error rate while locked.
// Optional feature macro: SYNC_CTRL_AUTO_RELOCK_EN (restart the sweep when a
// locked window exceeds LOCK_THR errors).
module ber_sync_ctrl
    import ber_sync_ctrl_pkg::*;
#(
    parameter int unsigned OS     = DEF_OS,
    parameter int unsigned NLAT   = DEF_NLAT,
    parameter int unsigned WINDOW = DEF_WINDOW,
    parameter int unsigned SETTLE = DEF_SETTLE
`ifdef SYNC_CTRL_AUTO_RELOCK_EN
    ,
    parameter int unsigned LOCK_THR = DEF_LOCK_THR
`endif
) (
    input  logic                          clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_sym_tick,
    input  logic                          i_err,
    output logic [$clog2(OS)-1:0]         o_phase,
    output logic [$clog2(NLAT)-1:0]       o_delay,
    output logic                          o_ber_clear,
    output logic                          o_locked,
    output logic [$clog2(WINDOW+1)-1:0]   o_best_err,
    output logic [$clog2(WINDOW+1)-1:0]   o_win_err
);
    localparam int unsigned PW = $clog2(OS);
    localparam int unsigned DW = $clog2(NLAT);
    localparam int unsigned CW = $clog2(WINDOW + 1);
    localparam int unsigned SW = $clog2(SETTLE + 1);

    sync_state_e   state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [PW-1:0] phase_q, phase_d, best_phase_q, best_phase_d;
    logic [DW-1:0] delay_q, delay_d, best_delay_q, best_delay_d;
    logic [CW-1:0] best_err_q, best_err_d, best_out_q, best_out_d;
    logic [CW-1:0] win_err_q, win_err_d;
    logic          ber_clear_q, ber_clear_d;
    logic          locked_q, locked_d;

    logic          cnt_en;
    logic          win_done_c;
    logic [CW-1:0] win_sum_c;
    logic          cand_win;
    logic          settle_done;

    assign cnt_en      = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);
    assign cand_win    = win_sum_c < best_err_q;
    assign settle_done = settle_q == SW'(SETTLE - 1);

    // Window counter shared by candidate measurement and lock monitoring.
    ber_window_cnt #(
        .WINDOW (WINDOW)
    ) u_win_cnt (
        .clk_i       (clock),
        .rst_ni      (i_reset),
        .clear_i     (!cnt_en),
        .en_i        (cnt_en),
        .tick_i      (i_sym_tick),
        .err_i       (i_err),
        .done_c_o    (win_done_c),
        .err_sum_c_o (win_sum_c)
    );

    // Next-state and registered-output decisions.
    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        phase_d      = phase_q;
        delay_d      = delay_q;
        best_phase_d = best_phase_q;
        best_delay_d = best_delay_q;
        best_err_d   = best_err_q;
        best_out_d   = best_out_q;
        win_err_d    = win_err_q;
        ber_clear_d  = 1'b0;
        locked_d     = locked_q;

        if (!i_enable) begin
            state_d      = ST_IDLE;
            settle_d     = '0;
            locked_d     = 1'b0;
            best_err_d   = '1;
            best_phase_d = '0;
            best_delay_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d     = ST_SETTLE;
                    settle_d    = '0;
                    phase_d     = '0;
                    delay_d     = '0;
                    ber_clear_d = 1'b1;
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        state_d = ST_MEASURE;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                ST_MEASURE: begin
                    if (win_done_c) begin
                        if (cand_win) begin
                            best_err_d   = win_sum_c;
                            best_phase_d = phase_q;
                            best_delay_d = delay_q;
                        end
                        settle_d    = '0;
                        ber_clear_d = 1'b1;
                        if (delay_q != DW'(NLAT - 1)) begin
                            state_d = ST_SETTLE;
                            delay_d = delay_q + DW'(1);
                        end else if (phase_q != PW'(OS - 1)) begin
                            state_d = ST_SETTLE;
                            delay_d = '0;
                            phase_d = phase_q + PW'(1);
                        end else begin
                            state_d    = ST_APPLY;
                            phase_d    = cand_win ? phase_q   : best_phase_q;
                            delay_d    = cand_win ? delay_q   : best_delay_q;
                            best_out_d = cand_win ? win_sum_c : best_err_q;
                        end
                    end
                end
                ST_APPLY: begin
                    if (settle_done) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (win_done_c) begin
                        win_err_d = win_sum_c;
`ifdef SYNC_CTRL_AUTO_RELOCK_EN
                        if (win_sum_c > CW'(LOCK_THR)) begin
                            state_d      = ST_SETTLE;
                            settle_d     = '0;
                            locked_d     = 1'b0;
                            phase_d      = '0;
                            delay_d      = '0;
                            ber_clear_d  = 1'b1;
                            best_err_d   = '1;
                            best_phase_d = '0;
                            best_delay_d = '0;
                        end
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            phase_q      <= '0;
            delay_q      <= '0;
            best_phase_q <= '0;
            best_delay_q <= '0;
            best_err_q   <= '1;
            best_out_q   <= '0;
            win_err_q    <= '0;
            ber_clear_q  <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            phase_q      <= phase_d;
            delay_q      <= delay_d;
            best_phase_q <= best_phase_d;
            best_delay_q <= best_delay_d;
            best_err_q   <= best_err_d;
            best_out_q   <= best_out_d;
            win_err_q    <= win_err_d;
            ber_clear_q  <= ber_clear_d;
            locked_q     <= locked_d;
        end
    end

    assign o_phase     = phase_q;
    assign o_delay     = delay_q;
    assign o_ber_clear = ber_clear_q;
    assign o_locked    = locked_q;
    assign o_best_err  = best_out_q;
    assign o_win_err   = win_err_q;

endmodule

// File: tb/tb_ber_sync_ctrl.sv
// Testbench for ber_sync_ctrl: a channel model scores each (phase, delay)
// candidate with a fixed error count per WINDOW consecutive symbols, and the
// expected winner is the first minimum over the candidate order.
module tb_ber_sync_ctrl;
    import ber_sync_ctrl_pkg::*;

    localparam int unsigned TB_OS     = DEF_OS;
    localparam int unsigned TB_NLAT   = 8;
    localparam int unsigned TB_WINDOW = 16;
    localparam int unsigned TB_SETTLE = 4;
    localparam int unsigned TB_TSYM   = 4;
    localparam int unsigned TB_THR    = DEF_LOCK_THR;
    localparam int          N_CAND    = int'(TB_OS * TB_NLAT);
    localparam int          SWEEP_MAX = N_CAND * int'(TB_SETTLE + TB_WINDOW * TB_TSYM + 1)
                                        + int'(TB_SETTLE) + 1;
    localparam int          SWEEP_MIN = SWEEP_MAX - N_CAND * int'(TB_TSYM);

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_enable;
    logic       i_sym_tick;
    logic       i_err;
    logic [1:0] o_phase;
    logic [2:0] o_delay;
    logic       o_ber_clear;
    logic       o_locked;
    logic [4:0] o_best_err;
    logic [4:0] o_win_err;

    int n_checks = 0;
    int n_fail   = 0;
    int kmap [TB_OS][TB_NLAT];

    ber_sync_ctrl #(
        .OS     (TB_OS),
        .NLAT   (TB_NLAT),
        .WINDOW (TB_WINDOW),
        .SETTLE (TB_SETTLE)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_sym_tick  (i_sym_tick),
        .i_err       (i_err),
        .o_phase     (o_phase),
        .o_delay     (o_delay),
        .o_ber_clear (o_ber_clear),
        .o_locked    (o_locked),
        .o_best_err  (o_best_err),
        .o_win_err   (o_win_err)
    );

    always #5 clock = ~clock;

    // Channel: one tick every TB_TSYM cycles; any WINDOW consecutive ticks
    // under candidate (p,d) carry exactly kmap[p][d] errors. Off-tick i_err
    // is random garbage that must be ignored.
    initial begin
        int ph;
        int tidx;
        ph = 0;
        tidx = 0;
        i_sym_tick = 1'b0;
        i_err = 1'b0;
        forever begin
            @(negedge clock);
            ph = (ph + 1) % int'(TB_TSYM);
            if (ph == 0) begin
                i_sym_tick = 1'b1;
                i_err = (tidx % int'(TB_WINDOW)) < kmap[o_phase][o_delay];
                tidx++;
            end else begin
                i_sym_tick = 1'b0;
                i_err = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic set_all(input int v);
        for (int p = 0; p < int'(TB_OS); p++)
            for (int d = 0; d < int'(TB_NLAT); d++)
                kmap[p][d] = v;
    endtask

    // Reference: first candidate (phase-major, delay-minor) with minimum errors.
    task automatic model_best(output int bp, output int bd, output int be);
        be = int'(TB_WINDOW) + 1;
        bp = 0;
        bd = 0;
        for (int p = 0; p < int'(TB_OS); p++)
            for (int d = 0; d < int'(TB_NLAT); d++)
                if (kmap[p][d] < be) begin
                    be = kmap[p][d];
                    bp = p;
                    bd = d;
                end
    endtask

    task automatic do_reset();
        i_enable = 1'b0;
        i_reset  = 1'b0;
        repeat (2) @(negedge clock);
        i_reset = 1'b1;
        @(negedge clock);
    endtask

    // Enable and count clock edges until o_locked (bounded).
    task automatic run_to_lock(output int n);
        i_enable = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (o_locked !== 1'b1 && n < SWEEP_MAX + 500);
    endtask

    // Bounded wait for a given candidate to be on the outputs.
    task automatic wait_cand(input int p, input int d, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < 2000 && !ok) begin
            @(negedge clock);
            n++;
            ok = (int'(o_phase) == p) && (int'(o_delay) == d);
        end
    endtask

    task automatic test_reset();
        i_enable = 1'b0;
        i_reset  = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({o_phase, o_delay, o_ber_clear, o_locked, o_best_err, o_win_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {o_phase, o_delay, o_ber_clear, o_locked, o_best_err, o_win_err});
        end
        i_reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if (o_ber_clear !== 1'b0 || o_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_disabled: clear=%b locked=%b expected 0 0", o_ber_clear, o_locked);
        end
    endtask

    task automatic check_lock(input string name);
        int bp, bd, be;
        model_best(bp, bd, be);
        n_checks++;
        if (o_locked !== 1'b1 || int'(o_phase) != bp || int'(o_delay) != bd
            || int'(o_best_err) != be) begin
            n_fail++;
            $display("FAIL %s: locked=%b phase=%0d delay=%0d best=%0d expected 1 %0d %0d %0d",
                     name, o_locked, o_phase, o_delay, o_best_err, bp, bd, be);
        end
    endtask

    task automatic test_single_clean();
        int n;
        set_all(int'(TB_WINDOW));
        kmap[2][5] = 0;
        do_reset();
        run_to_lock(n);
        check_lock("single_clean");
        n_checks++;
        if (n < SWEEP_MIN || n > SWEEP_MAX) begin
            n_fail++;
            $display("FAIL sweep_duration: got %0d cycles expected %0d..%0d", n, SWEEP_MIN, SWEEP_MAX);
        end
    endtask

    task automatic test_tie();
        int n;
        set_all(int'(TB_WINDOW));
        kmap[1][3] = 2;
        kmap[3][6] = 2;
        do_reset();
        run_to_lock(n);
        check_lock("tie");
    endtask

    task automatic test_random(input int trials);
        int n, bp, bd, be;
        for (int t = 0; t < trials; t++) begin
            for (int p = 0; p < int'(TB_OS); p++)
                for (int d = 0; d < int'(TB_NLAT); d++)
                    kmap[p][d] = int'($urandom_range(0, TB_WINDOW));
            kmap[$urandom_range(0, TB_OS - 1)][$urandom_range(0, TB_NLAT - 1)] =
                int'($urandom_range(0, TB_THR));
            do_reset();
            run_to_lock(n);
            check_lock("random_lock");
            model_best(bp, bd, be);
            repeat ((TB_WINDOW + 2) * TB_TSYM) @(negedge clock);
            n_checks++;
            if (int'(o_win_err) != be || o_locked !== 1'b1) begin
                n_fail++;
                $display("FAIL random_win_err: got %0d locked=%b expected %0d locked=1",
                         o_win_err, o_locked, be);
            end
        end
    endtask

    task automatic test_disable();
        bit ok, bad;
        int n;
        set_all(int'(TB_WINDOW));
        kmap[2][5] = 0;
        do_reset();
        i_enable = 1'b1;
        wait_cand(0, 4, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reach_0_4: phase=%0d delay=%0d expected 0 4", o_phase, o_delay);
        end
        repeat (TB_SETTLE + 8) @(negedge clock);
        i_enable = 1'b0;
        @(negedge clock);
        n_checks++;
        if (o_locked !== 1'b0 || o_ber_clear !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_next: locked=%b clear=%b expected 0 0", o_locked, o_ber_clear);
        end
        bad = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (o_ber_clear !== 1'b0 || o_delay !== 3'd4 || o_phase !== 2'd0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL disable_hold: clear=%b phase=%0d delay=%0d expected 0 0 4",
                     o_ber_clear, o_phase, o_delay);
        end
        i_enable = 1'b1;
        @(negedge clock);
        n_checks++;
        if (o_ber_clear !== 1'b1 || o_phase !== 2'd0 || o_delay !== 3'd0) begin
            n_fail++;
            $display("FAIL reenable_start: clear=%b phase=%0d delay=%0d expected 1 0 0",
                     o_ber_clear, o_phase, o_delay);
        end
        run_to_lock(n);
        check_lock("relock_after_reenable");
        i_enable = 1'b0;
        @(negedge clock);
        n_checks++;
        if (o_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_locked: locked=%b expected 0", o_locked);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        set_all(int'(TB_WINDOW));
        do_reset();
        i_enable = 1'b1;
        wait_cand(0, 3, ok);
        repeat (TB_SETTLE + 6) @(negedge clock);
        #2 i_reset = 1'b0;
        #1;
        n_checks++;
        if ({o_phase, o_delay, o_ber_clear, o_locked, o_best_err, o_win_err} !== '0 || !ok) begin
            n_fail++;
            $display("FAIL async_reset: got %h reached=%b expected 0 1",
                     {o_phase, o_delay, o_ber_clear, o_locked, o_best_err, o_win_err}, ok);
        end
        @(negedge clock);
        i_enable = 1'b0;
        i_reset  = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_relock();
        int n;
        bit seen;
        set_all(int'(TB_WINDOW));
        kmap[2][5] = 0;
        do_reset();
        run_to_lock(n);
        check_lock("relock_base");
        kmap[2][5] = int'(TB_THR) + 1;
        seen = 1'b0;
        repeat ((2 * TB_WINDOW + 2) * TB_TSYM) begin
            @(negedge clock);
            if (o_locked === 1'b0 && !seen) begin
                seen = 1'b1;
                n_checks++;
                if (o_ber_clear !== 1'b1 || o_phase !== 2'd0 || o_delay !== 3'd0) begin
                    n_fail++;
                    $display("FAIL relock_restart: clear=%b phase=%0d delay=%0d expected 1 0 0",
                             o_ber_clear, o_phase, o_delay);
                end
            end
        end
        n_checks++;
        if (int'(o_win_err) != int'(TB_THR) + 1) begin
            n_fail++;
            $display("FAIL relock_win_err: got %0d expected %0d", o_win_err, TB_THR + 1);
        end
`ifdef SYNC_CTRL_AUTO_RELOCK_EN
        n_checks++;
        if (!seen || o_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_drop: seen=%b locked=%b expected 1 0", seen, o_locked);
        end
`else
        n_checks++;
        if (seen || o_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_hold: dropped=%b locked=%b expected 0 1", seen, o_locked);
        end
`endif
    endtask

    initial begin
        set_all(int'(TB_WINDOW));
        i_enable = 1'b0;
        i_reset  = 1'b0;
        test_reset();
        test_single_clean();
        test_tie();
        test_random(3);
        test_disable();
        test_async_reset();
        test_relock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
